// File: rtl/load_store_unit_if.sv
// load_store_unit_if: LSB request/response, ROB rollback, CDB broadcast and byte-wide memory port
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic enable_from_lsb;
  logic read_write_flag_from_lsb;
  logic [2:0] op_enum_from_lsb;
  logic [ADDR_W-1:0] object_address_from_lsb;
  logic [DATA_W-1:0] data_from_lsb;
  logic roll_back_flag_from_rob;
  logic busy_to_lsb;
  logic end_to_lsb;
  logic [DATA_W-1:0] data_to_lsb;
  logic enable_to_cdb;
  logic [DATA_W-1:0] result_to_cdb;
  logic mem_req_out;
  logic mem_grant_in;
  logic [ADDR_W-1:0] mem_a_out;
  logic mem_wr_out;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  logic io_buffer_full_in;
  modport slave (
    input  enable_from_lsb, read_write_flag_from_lsb, op_enum_from_lsb, object_address_from_lsb,
    input  data_from_lsb, roll_back_flag_from_rob, mem_grant_in, mem_din, io_buffer_full_in,
    output busy_to_lsb, end_to_lsb, data_to_lsb, enable_to_cdb, result_to_cdb,
    output mem_req_out, mem_a_out, mem_wr_out, mem_dout
  );
  modport master (
    output enable_from_lsb, read_write_flag_from_lsb, op_enum_from_lsb, object_address_from_lsb,
    output data_from_lsb, roll_back_flag_from_rob, mem_grant_in, mem_din, io_buffer_full_in,
    input  busy_to_lsb, end_to_lsb, data_to_lsb, enable_to_cdb, result_to_cdb,
    input  mem_req_out, mem_a_out, mem_wr_out, mem_dout
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: runs one byte-sequenced load/store at a time with extension, rollback and I/O stall
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] IO_PORT = ADDR_W'('h30000)
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6;
  typedef enum logic [2:0] {IDLE, REQ, XFER, FLUSH, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d, last_q, pidx_q;
  logic store_q, sgn_q, pend_q, abort_q, abort_d, end_q, cdb_q;
  logic [ADDR_W-1:0] addr_q, byte_a;
  logic [DATA_W-1:0] wdata_q, buf_q, data_q, ext;
  logic [2:0] op;
  logic active, abort, accept, stall;
  assign op = bus.op_enum_from_lsb;
  assign byte_a = addr_q + ADDR_W'(idx_q);
  assign active = state_q inside {REQ, XFER, FLUSH};
  assign abort = active & bus.roll_back_flag_from_rob & ~store_q;
  assign accept = state_q == IDLE & bus.enable_from_lsb & (bus.read_write_flag_from_lsb | ~bus.roll_back_flag_from_rob);
  assign stall = state_q == XFER & store_q & byte_a >= IO_PORT & bus.io_buffer_full_in;
  assign ext = last_q == 2'd0 ? {{(DATA_W-8){sgn_q & buf_q[7]}}, buf_q[7:0]} :
               last_q == 2'd1 ? {{(DATA_W-16){sgn_q & buf_q[15]}}, buf_q[15:0]} : buf_q;
  assign bus.busy_to_lsb = state_q != IDLE;
  assign bus.end_to_lsb = end_q;
  assign bus.enable_to_cdb = cdb_q;
  assign bus.data_to_lsb = data_q;
  assign bus.result_to_cdb = data_q;
  assign bus.mem_req_out = active;
  assign bus.mem_a_out = state_q == XFER ? byte_a : '0;
  assign bus.mem_wr_out = state_q == XFER & store_q & ~stall;
  assign bus.mem_dout = state_q == XFER & store_q ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    abort_d = accept ? 1'b0 : abort_q | abort;
    case (state_q)
      IDLE: state_d = accept ? REQ : IDLE;
      REQ: begin
        idx_d = 2'd0;
        state_d = abort ? DONE : bus.mem_grant_in ? XFER : REQ;
      end
      XFER: begin
        idx_d = stall ? idx_q : idx_q + 2'd1;
        state_d = abort ? DONE : (stall | idx_q != last_q) ? XFER : store_q ? DONE : FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q <= '0;
      last_q <= '0;
      pidx_q <= '0;
      store_q <= 1'b0;
      sgn_q <= 1'b0;
      pend_q <= 1'b0;
      abort_q <= 1'b0;
      end_q <= 1'b0;
      cdb_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      data_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      idx_q <= idx_d;
      abort_q <= abort_d;
      pend_q <= state_q == XFER & ~store_q & ~abort;
      pidx_q <= idx_q;
      if (pend_q) buf_q[{pidx_q, 3'b000} +: 8] <= bus.mem_din;
      if (accept) begin
        store_q <= bus.read_write_flag_from_lsb;
        sgn_q <= op == LB | op == LH;
        last_q <= (op == LB | op == LBU | op == SB) ? 2'd0 : (op == LH | op == LHU | op == SH) ? 2'd1 : 2'd3;
        addr_q <= bus.object_address_from_lsb;
        wdata_q <= bus.data_from_lsb;
      end
      end_q <= state_q == DONE;
      cdb_q <= state_q == DONE & ~store_q & ~abort_q & ~bus.roll_back_flag_from_rob;
      if (state_q == DONE & ~store_q & ~abort_q) data_q <= ext;
    end
  end
endmodule
